// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents: request size encodings, FSM state encoding, byte-enable lane patterns,
// and the captured request payload.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // decoded the same as SZ_WORD

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Request attributes held for the whole access. The word index is kept
  // separately because its width depends on a parameter.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lo;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane steering for the data-memory responder.
// Ports:
//   size_i, lo_i    access size and byte offset (addr[1:0])
//   sgn_i           load sign-extension select
//   wdata_i         right-aligned store data
//   raw_i           raw RAM word read for a load
//   be_o            per-byte write enables
//   wdata_o         store data replicated across all lanes
//   misalign_o      half on an odd address, or word not on a word boundary
//   rdata_o         load data shifted down and extended
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = raw_i[{lo_i, 3'b000} +: 8];
    half_sel   = lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    be_o       = BE_WORD;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    rdata_o    = raw_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE0 << lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o       = lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = lo_i[0];
        rdata_o    = {{16{sgn_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD, SZ_RSVD: begin
        be_o       = BE_WORD;
        misalign_o = (lo_i != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage loads/stores with programmable latency.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   req_valid/we/size/signed/addr/wdata   MEM-stage request
//   stall                 combinational: access in flight, freeze pipeline
//   rdata, rdata_valid    registered load result and its one-cycle pulse
//   addr_err              registered one-cycle pulse for a rejected misaligned request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  req_t                req_q, req_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                mem_we;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         raw;

  logic [1:0]          lane_size;
  logic [1:0]          lane_lo;
  logic                lane_sgn;
  logic [31:0]         lane_wdata;
  logic [3:0]          be;
  logic [31:0]         wdata_rep;
  logic                misalign;
  logic [31:0]         ld_ext;

  // Address bits above the word index wrap and are intentionally ignored.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Live request is decoded in IDLE; the captured request drives the access.
  always_comb begin
    if (state_q == ST_IDLE) begin
      lane_size  = req_size;
      lane_lo    = req_addr[1:0];
      lane_sgn   = req_signed;
      lane_wdata = req_wdata;
    end else begin
      lane_size  = req_q.size;
      lane_lo    = req_q.lo;
      lane_sgn   = req_q.sgn;
      lane_wdata = req_q.wdata;
    end
  end

  assign raw = mem[idx_q];

  dmem_lane_ctrl u_lane (
    .size_i     (lane_size),
    .lo_i       (lane_lo),
    .sgn_i      (lane_sgn),
    .wdata_i    (lane_wdata),
    .raw_i      (raw),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .misalign_o (misalign),
    .rdata_o    (ld_ext)
  );

  assign stall = req_valid & ~misalign & (state_q != ST_DONE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    idx_d         = idx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            addr_err_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            req_d   = '{we: req_we, size: req_size, sgn: req_signed,
                        lo: req_addr[1:0], wdata: req_wdata};
            idx_d   = req_addr[ADDR_W+1:2];
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          if (req_q.we) begin
            mem_we = 1'b1;
          end else begin
            rdata_d       = ld_ext;
            rdata_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      idx_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      idx_q         <= idx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Word RAM with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// loads/stores against a word-array reference model, on a LATENCY=2 and a
// LATENCY=1 instance sharing the request data bus.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall0, stall1;
  logic [31:0] rdata0, rdata1;
  logic        rv0, rv1;
  logic        err0, err1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [2][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_we(we), .req_size(size),
    .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .stall(stall0), .rdata(rdata0), .rdata_valid(rv0), .addr_err(err0)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(we), .req_size(size),
    .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .stall(stall1), .rdata(rdata1), .rdata_valid(rv1), .addr_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_stall(input int s);
    return {31'b0, (s != 0) ? stall1 : stall0};
  endfunction
  function automatic logic [31:0] o_rv(input int s);
    return {31'b0, (s != 0) ? rv1 : rv0};
  endfunction
  function automatic logic [31:0] o_err(input int s);
    return {31'b0, (s != 0) ? err1 : err0};
  endfunction
  function automatic logic [31:0] o_rdata(input int s);
    return (s != 0) ? rdata1 : rdata0;
  endfunction

  task automatic set_valid(input int s, input logic v);
    if (s != 0) v1 = v;
    else        v0 = v;
  endtask

  function automatic bit mdl_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (lo % 2) != 0;
    return lo != 2'd0;
  endfunction

  function automatic logic [31:0] mdl_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'h0000_00FF;
    if (sz == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lo);
    logic [31:0] v;
    v = (word >> (int'(lo) * 8)) & mdl_mask(sz);
    if (sg && sz == 2'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (sg && sz == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // One complete request on DUT s, checked against the model; got = load result.
  task automatic access(input int s, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    int          lat;
    int          n;
    int          idx;
    logic [31:0] m;
    lat = (s != 0) ? 1 : 2;
    idx = int'((a >> 2) & 32'd1023);
    got = '0;
    @(posedge clk); #1;
    we = w; size = sz; sgn = sg; addr = a; wdata = d;
    set_valid(s, 1'b1);
    #1;
    if (mdl_misaligned(sz, a[1:0])) begin
      check("mis_stall", o_stall(s), 32'd0);
      @(posedge clk); #1;
      set_valid(s, 1'b0);
      #1;
      check("mis_err", o_err(s), 32'd1);
      check("mis_rv", o_rv(s), 32'd0);
      @(posedge clk); #2;
      check("mis_err_clr", o_err(s), 32'd0);
      return;
    end
    n = 0;
    while (o_stall(s) != 0 && n < 20) begin
      n++;
      @(posedge clk); #2;
    end
    check("stall_cycles", 32'(n), 32'(lat + 1));
    check("done_rv", o_rv(s), {31'b0, ~w});
    if (!w) begin
      got = o_rdata(s);
      check("rdata", got, mdl_load(mdl[s][idx], sz, sg, a[1:0]));
    end else begin
      m = mdl_mask(sz) << (int'(a[1:0]) * 8);
      mdl[s][idx] = (mdl[s][idx] & ~m) | ((d & mdl_mask(sz)) << (int'(a[1:0]) * 8));
    end
    set_valid(s, 1'b0);
    @(posedge clk); #2;
    check("rv_clear", o_rv(s), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; we = 1'b0; size = 2'd0; sgn = 1'b0;
    addr = '0; wdata = '0;
    #23;
    check("rst_stall", {31'b0, stall0}, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_rv", {31'b0, rv0}, 32'd0);
    check("rst_err", {31'b0, err0}, 32'd0);
    rst = 1'b1;

    // Word store then load, and sub-word loads of the same word.
    access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lw_10", got, 32'hDEAD_BEEF);
    access(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
    check("lb_13", got, 32'hFFFF_FFDE);
    access(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, got);
    check("lbu_13", got, 32'h0000_00DE);
    access(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, got);
    check("lh_12", got, 32'hFFFF_DEAD);
    access(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, got);
    check("lhu_10", got, 32'h0000_BEEF);

    // Byte store keeps other lanes; upper address bits wrap.
    access(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, got);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lw_after_sb", got, 32'hDEAD_AAEF);
    access(0, 1'b0, 2'd2, 1'b0, 32'h1000_1010, 32'h0, got);
    check("lw_wrap", got, 32'hDEAD_AAEF);

    // Misaligned requests rejected without touching RAM.
    access(0, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, got);
    access(0, 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000_5555, got);
    access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lw_after_mis", got, 32'hDEAD_AAEF);

    // Asynchronous reset in the middle of a load.
    @(posedge clk); #1;
    we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h10; v0 = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0; v0 = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall0}, 32'd0);
    check("midrst_rdata", rdata0, 32'd0);
    check("midrst_rv", {31'b0, rv0}, 32'd0);
    check("midrst_err", {31'b0, err0}, 32'd0);
    #2 rst = 1'b1;

    // Store dropped by a reset during WAIT.
    access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, got);
    @(posedge clk); #1;
    we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h1234_5678; v0 = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; v0 = 1'b0;
    #2 rst = 1'b1;
    access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
    check("lw_after_rst_store", got, 32'h0000_0000);

    // LATENCY=1 instance.
    access(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
    access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lat1_lw_10", got, 32'hDEAD_BEEF);

    // Randomized traffic over a 16-word window on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        access(s, 1'b1, 2'd2, 1'b0, 32'h40 + 32'(4 * i), $urandom, got);
      for (int i = 0; i < 60; i++) begin
        a = ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 63)));
        access(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
